// File: rtl/pipe_adder_n_pkg.sv
// Shared constants for the segmented pipelined adder: default widths and
// the stage-count derivation used by the top level.
package adder_pkg;

  localparam int unsigned WIDTH_DEF = 36;
  localparam int unsigned SEG_DEF   = 12;

  function automatic int unsigned stages(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipe_adder_n_if.sv
// Operand/result handshake bundle for pipe_adder_n; master drives operands
// and accepts results, slave is the adder itself.
interface pipe_adder_n_if #(parameter int unsigned WIDTH = adder_pkg::WIDTH_DEF);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             ca;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, ca, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, ca, ovf
  );

endinterface

// File: rtl/pipe_adder_n_seg.sv
// One SEG-bit slice of the pipelined adder: sum, carry-out and the carry
// into the slice MSB (needed for signed overflow on the top slice).
module adder_seg #(
  parameter int unsigned SEG = 12
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cm
);

  logic [SEG:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  assign s    = full[SEG-1:0];
  assign co   = full[SEG];
  // MSB sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR
  assign cm   = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipe_adder_n.sv
// Carry-pipelined adder/subtractor: one SEG-bit slice per stage, with
// operand skew ahead of the active slice and result de-skew behind it.
module pipe_adder_n
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SEG   = SEG_DEF
) (
  input logic         clk,
  input logic         rst,
  pipe_adder_n_if.slave bus
);

  localparam int unsigned STAGES = stages(WIDTH, SEG);

  typedef logic [SEG-1:0] seg_t;

  // [stage][segment]; stage k only consumes segment k of the operands and
  // only produces segment k of the result, the rest is forwarded as-is.
  seg_t ap [STAGES][STAGES];
  seg_t bp [STAGES][STAGES];
  seg_t rp [STAGES][STAGES];
  seg_t sa [STAGES][STAGES];
  seg_t sb [STAGES][STAGES];
  seg_t sr [STAGES][STAGES];
  logic sc [STAGES];
  logic sv [STAGES];

  seg_t ss [STAGES];
  logic co [STAGES];
  logic cm [STAGES];

  logic [STAGES-1:0] c;
  logic [STAGES-1:0] v;
  logic              ov;
  logic              adv;
  logic [WIDTH-1:0]  bx;
  logic [WIDTH-1:0]  sum_w;

  assign adv          = !v[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;
  assign bx           = bus.sub ? ~bus.b : bus.b;

  always_comb begin
    for (int unsigned j = 0; j < STAGES; j++) begin
      sa[0][j] = bus.a[j*SEG +: SEG];
      sb[0][j] = bx[j*SEG +: SEG];
      sr[0][j] = '0;
    end
    sc[0] = bus.sub | bus.cin;
    sv[0] = bus.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      for (int unsigned j = 0; j < STAGES; j++) begin
        sa[k][j] = ap[k-1][j];
        sb[k][j] = bp[k-1][j];
        sr[k][j] = rp[k-1][j];
      end
      sc[k] = c[k-1];
      sv[k] = v[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_seg #(.SEG(SEG)) u_seg (
      .a  (sa[k][k]),
      .b  (sb[k][k]),
      .ci (sc[k]),
      .s  (ss[k]),
      .co (co[k]),
      .cm (cm[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v  <= '0;
      c  <= '0;
      ov <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        for (int unsigned j = 0; j < STAGES; j++) begin
          ap[k][j] <= '0;
          bp[k][j] <= '0;
          rp[k][j] <= '0;
        end
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v[k] <= sv[k];
        c[k] <= co[k];
        for (int unsigned j = 0; j < STAGES; j++) begin
          ap[k][j] <= sa[k][j];
          bp[k][j] <= sb[k][j];
          rp[k][j] <= (j == k) ? ss[k] : sr[k][j];
        end
      end
      ov <= cm[STAGES-1] ^ co[STAGES-1];
    end
  end

  always_comb begin
    sum_w = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      sum_w[j*SEG +: SEG] = rp[STAGES-1][j];
    end
  end

  assign bus.sum       = sum_w;
  assign bus.ca        = c[STAGES-1];
  assign bus.ovf       = ov;
  assign bus.out_valid = v[STAGES-1];

endmodule

// File: tb/tb_pipe_adder_n.sv
// Directed and scoreboarded checks for pipe_adder_n at WIDTH=36, SEG=12.
module tb_pipe_adder_n;

  localparam int unsigned W  = 36;
  localparam int unsigned SG = 12;
  localparam int unsigned ST = W / SG;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipe_adder_n_if #(.WIDTH(W)) bus ();

  pipe_adder_n #(.WIDTH(W), .SEG(SG)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         ca;
    logic         ov;
  } vec_t;

  vec_t vt [7] = '{
    '{36'hFFFFFFFFF, 36'h000000001, 1'b0, 1'b0, 36'h000000000, 1'b1, 1'b0},
    '{36'h000000FFF, 36'h000000001, 1'b0, 1'b0, 36'h000001000, 1'b0, 1'b0},
    '{36'h000000005, 36'h000000007, 1'b0, 1'b1, 36'hFFFFFFFFE, 1'b0, 1'b0},
    '{36'h7FFFFFFFF, 36'h000000001, 1'b0, 1'b0, 36'h800000000, 1'b0, 1'b1},
    '{36'h123456789, 36'h111111111, 1'b1, 1'b0, 36'h23456789B, 1'b0, 1'b0},
    '{36'h100000000, 36'h000000001, 1'b1, 1'b1, 36'h0FFFFFFFF, 1'b1, 1'b0},
    '{36'h800000000, 36'h000000001, 1'b0, 1'b1, 36'h7FFFFFFFF, 1'b1, 1'b1}
  };

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {ovf, ca, sum} computed as a plain wide addition
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   t;
    logic         o;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    o  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return {o, t};
  endfunction

  // Caller is #1 after an edge with an empty pipe and out_ready=1.
  task automatic send_chk(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W-1:0] s,
                          input logic ca, input logic ov);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    #1;
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < int'(ST) - 1; i++) begin
      chk({tag, "_early"}, 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(bus.sum), 64'(s));
    chk({tag, "_ca"}, 64'(bus.ca), 64'(ca));
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'(ov));
    @(posedge clk); #1;
    chk({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] q [$];
    logic [W+1:0] exp_cur;
    logic [63:0]  r;
    int           sent;
    int           got;
    int           seen;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    exp_cur = '0;

    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_ca", 64'(bus.ca), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      send_chk($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].sub,
               vt[i].s, vt[i].ca, vt[i].ov);

    // Random traffic with bubbles and downstream stalls against a scoreboard.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 20 && $urandom_range(0, 3) != 0) begin
        r = {$urandom(), $urandom()};
        bus.a = r[W-1:0];
        r = {$urandom(), $urandom()};
        bus.b = r[W-1:0];
        if (sent % 5 == 0) bus.a = '1;
        bus.cin = r[63];
        bus.sub = r[62];
        bus.in_valid = 1'b1;
        exp_cur = model(bus.a, bus.b, bus.cin, bus.sub);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 64'(bus.out_valid), 64'd0);
        end else begin
          chk("rnd_result", 64'({bus.ovf, bus.ca, bus.sum}), 64'(q[0]));
          if (bus.out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(exp_cur);
        sent++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("rnd_count", 64'(got), 64'd20);

    // Reset pulse with two operations in flight, one already at the output.
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.a = 36'h1; bus.b = 36'h2; bus.cin = 1'b0; bus.sub = 1'b0;
    @(posedge clk); #1;
    bus.a = 36'h3; bus.b = 36'h4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_async_sum", 64'(bus.sum), 64'd0);
    chk("rst_async_ca", 64'(bus.ca), 64'd0);
    chk("rst_async_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("rst_no_leak", 64'(seen), 64'd0);
    send_chk("post_rst", 36'h00ABCDEF0, 36'h000000111, 1'b0, 1'b0, 36'h00ABCE001, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
